// File: rtl/tx_point_test_ctrl.sv
// TX-initiated point-test sequencer: start / LFSR-clear / pattern / result / end
// sideband exchange with the partner, returning an ack and a 16-lane pass mask.
module tx_point_test_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 8000000,
  parameter int unsigned CNT_W          = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic        i_tx_lfsr_or_perlane,
  input  logic        i_tx_mainband_or_valtrain_test,
  input  logic [3:0]  i_sideband_message,
  input  logic        i_sideband_valid,
  input  logic [15:0] i_sideband_data,
  input  logic        i_busy,
  input  logic        i_pattern_done,
  output logic [3:0]  o_sideband_message,
  output logic        o_valid,
  output logic        o_pattern_en,
  output logic        o_pattern_lfsr,
  output logic        o_lfsr_clear,
  output logic        o_point_test_ack,
  output logic [15:0] o_lanes_result,
  output logic        o_timeout
);

  localparam logic [3:0] MSG_NONE        = 4'd0;
  localparam logic [3:0] MSG_START_REQ   = 4'd1;
  localparam logic [3:0] MSG_START_RESP  = 4'd2;
  localparam logic [3:0] MSG_CLEAR_REQ   = 4'd3;
  localparam logic [3:0] MSG_CLEAR_RESP  = 4'd4;
  localparam logic [3:0] MSG_RESULT_REQ  = 4'd5;
  localparam logic [3:0] MSG_RESULT_RESP = 4'd6;
  localparam logic [3:0] MSG_END_REQ     = 4'd7;
  localparam logic [3:0] MSG_END_RESP    = 4'd8;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, SEND_START, WAIT_START, SEND_CLEAR, WAIT_CLEAR, PATTERN,
    SEND_RESULT, WAIT_RESULT, SEND_END, WAIT_END, DONE
  } state_t;

  function automatic logic [3:0] send_code(input state_t s);
    case (s)
      SEND_START:  return MSG_START_REQ;
      SEND_CLEAR:  return MSG_CLEAR_REQ;
      SEND_RESULT: return MSG_RESULT_REQ;
      SEND_END:    return MSG_END_REQ;
      default:     return MSG_NONE;
    endcase
  endfunction

  function automatic logic [3:0] rsp_code(input state_t s);
    case (s)
      WAIT_START:  return MSG_START_RESP;
      WAIT_CLEAR:  return MSG_CLEAR_RESP;
      WAIT_RESULT: return MSG_RESULT_RESP;
      WAIT_END:    return MSG_END_RESP;
      default:     return MSG_NONE;
    endcase
  endfunction

  // Successor along the normal handshake path.
  function automatic state_t advance(input state_t s);
    case (s)
      SEND_START:  return WAIT_START;
      WAIT_START:  return SEND_CLEAR;
      SEND_CLEAR:  return WAIT_CLEAR;
      WAIT_CLEAR:  return PATTERN;
      PATTERN:     return SEND_RESULT;
      SEND_RESULT: return WAIT_RESULT;
      WAIT_RESULT: return SEND_END;
      SEND_END:    return WAIT_END;
      WAIT_END:    return DONE;
      default:     return s;
    endcase
  endfunction

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              mode_mb, mode_mb_nx;
  logic              lfsr_nx, valid_nx, clear_nx, timeout_nx, to_hit;
  logic [15:0]       result_nx;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_nx   = state;
    mode_mb_nx = mode_mb;
    lfsr_nx    = o_pattern_lfsr;
    valid_nx   = 1'b0;
    clear_nx   = 1'b0;
    result_nx  = o_lanes_result;
    timeout_nx = o_timeout;
    to_hit     = 1'b0;

    case (state)
      IDLE: begin
        result_nx  = '0;
        timeout_nx = 1'b0;
        if (i_en) begin
          state_nx   = SEND_START;
          lfsr_nx    = i_tx_lfsr_or_perlane;
          mode_mb_nx = i_tx_mainband_or_valtrain_test;
        end
      end
      SEND_START, SEND_CLEAR, SEND_RESULT, SEND_END: begin
        // The strobe goes out first; the state follows one cycle later.
        if (o_valid)             state_nx = advance(state);
        else if (cnt == CNT_LAST) to_hit  = 1'b1;
        else if (!i_busy)        valid_nx = 1'b1;
      end
      WAIT_START, WAIT_CLEAR, WAIT_RESULT, WAIT_END: begin
        if (i_sideband_valid && i_sideband_message == rsp_code(state)) begin
          state_nx = advance(state);
          if (state == WAIT_CLEAR) clear_nx = 1'b1;
          if (state == WAIT_RESULT)
            result_nx = mode_mb ? i_sideband_data : {16{i_sideband_data[0]}};
        end else if (cnt == CNT_LAST) begin
          to_hit = 1'b1;
        end
      end
      PATTERN: begin
        if (i_pattern_done)        state_nx = SEND_RESULT;
        else if (cnt == CNT_LAST)  to_hit   = 1'b1;
      end
      default: ;
    endcase

    if (to_hit) begin
      state_nx   = DONE;
      timeout_nx = 1'b1;
      result_nx  = '0;
    end

    // Dropping the enable overrides everything, including an arriving response.
    if (!i_en) begin
      state_nx   = IDLE;
      valid_nx   = 1'b0;
      clear_nx   = 1'b0;
      result_nx  = '0;
      timeout_nx = 1'b0;
    end

    if (state_nx != state || state == IDLE || state == DONE) cnt_nx = '0;
    else                                                     cnt_nx = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      cnt                <= '0;
      mode_mb            <= 1'b0;
      o_sideband_message <= MSG_NONE;
      o_valid            <= 1'b0;
      o_pattern_en       <= 1'b0;
      o_pattern_lfsr     <= 1'b0;
      o_lfsr_clear       <= 1'b0;
      o_point_test_ack   <= 1'b0;
      o_lanes_result     <= '0;
      o_timeout          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state              <= state_nx;
      cnt                <= cnt_nx;
      mode_mb            <= mode_mb_nx;
      o_sideband_message <= send_code(state_nx);
      o_valid            <= valid_nx;
      o_pattern_en       <= (state_nx == PATTERN);
      o_pattern_lfsr     <= lfsr_nx;
      o_lfsr_clear       <= clear_nx;
      o_point_test_ack   <= (state_nx == DONE);
      o_lanes_result     <= result_nx;
      o_timeout          <= timeout_nx;
    end
  end

endmodule

// File: tb/tb_tx_point_test_ctrl.sv
// Self-checking bench for tx_point_test_ctrl: table-driven full exchanges plus
// hand-written corner sequences (busy stall, timeout, abort, spurious, reset).
module tb_tx_point_test_ctrl;

  localparam int unsigned TO = 100;

  localparam logic [3:0] START_RESP  = 4'd2;
  localparam logic [3:0] CLEAR_RESP  = 4'd4;
  localparam logic [3:0] RESULT_RESP = 4'd6;
  localparam logic [3:0] END_RESP    = 4'd8;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_en, i_tx_lfsr_or_perlane, i_tx_mainband_or_valtrain_test;
  logic [3:0]  i_sideband_message;
  logic        i_sideband_valid;
  logic [15:0] i_sideband_data;
  logic        i_busy, i_pattern_done;
  logic [3:0]  o_sideband_message;
  logic        o_valid, o_pattern_en, o_pattern_lfsr, o_lfsr_clear;
  logic        o_point_test_ack, o_timeout;
  logic [15:0] o_lanes_result;

  tx_point_test_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk                            (clk),
    .rst                            (rst),
    .i_en                           (i_en),
    .i_tx_lfsr_or_perlane           (i_tx_lfsr_or_perlane),
    .i_tx_mainband_or_valtrain_test (i_tx_mainband_or_valtrain_test),
    .i_sideband_message             (i_sideband_message),
    .i_sideband_valid               (i_sideband_valid),
    .i_sideband_data                (i_sideband_data),
    .i_busy                         (i_busy),
    .i_pattern_done                 (i_pattern_done),
    .o_sideband_message             (o_sideband_message),
    .o_valid                        (o_valid),
    .o_pattern_en                   (o_pattern_en),
    .o_pattern_lfsr                 (o_pattern_lfsr),
    .o_lfsr_clear                   (o_lfsr_clear),
    .o_point_test_ack               (o_point_test_ack),
    .o_lanes_result                 (o_lanes_result),
    .o_timeout                      (o_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        lfsr;
    logic        mb;
    logic [15:0] data;
    int          delay;
    logic [15:0] exp_result;
  } vec_t;

  vec_t vecs[4];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    i_sideband_valid   = 1'b0;
    i_sideband_message = 4'd0;
    i_pattern_done     = 1'b0;
  endtask

  task automatic respond(input logic [3:0] code, input logic [15:0] data);
    i_sideband_valid   = 1'b1;
    i_sideband_message = code;
    i_sideband_data    = data;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!o_valid && lat < 300);
  endtask

  task automatic run_vector(input vec_t v, input int idx);
    int    lat;
    string t;
    t = $sformatf("v%0d", idx);
    i_tx_lfsr_or_perlane           = v.lfsr;
    i_tx_mainband_or_valtrain_test = v.mb;
    i_en                           = 1'b1;
    wait_valid(lat);
    check({t, ".start_lat"}, lat, 2);
    check({t, ".start_code"}, o_sideband_message, 1);
    tick();
    check({t, ".start_pulse_width"}, o_valid, 0);
    check({t, ".pattern_lfsr"}, o_pattern_lfsr, v.lfsr);

    repeat (v.delay) tick();
    respond(START_RESP, 16'h0);
    wait_valid(lat);
    check({t, ".clear_lat"}, lat, 2);
    check({t, ".clear_code"}, o_sideband_message, 3);
    tick();

    repeat (v.delay) tick();
    respond(CLEAR_RESP, 16'h0);
    tick();
    check({t, ".lfsr_clear_on"}, o_lfsr_clear, 1);
    check({t, ".pattern_en_on"}, o_pattern_en, 1);
    tick();
    check({t, ".lfsr_clear_off"}, o_lfsr_clear, 0);
    check({t, ".pattern_en_held"}, o_pattern_en, 1);

    repeat (3) tick();
    i_pattern_done = 1'b1;
    wait_valid(lat);
    check({t, ".result_lat"}, lat, 2);
    check({t, ".result_code"}, o_sideband_message, 5);
    check({t, ".pattern_en_off"}, o_pattern_en, 0);
    tick();

    repeat (v.delay) tick();
    respond(RESULT_RESP, v.data);
    wait_valid(lat);
    check({t, ".end_lat"}, lat, 2);
    check({t, ".end_code"}, o_sideband_message, 7);
    tick();

    repeat (v.delay) tick();
    respond(END_RESP, 16'h0);
    check({t, ".ack_before"}, o_point_test_ack, 0);
    tick();
    check({t, ".ack"}, o_point_test_ack, 1);
    check({t, ".lanes_result"}, o_lanes_result, v.exp_result);
    check({t, ".timeout"}, o_timeout, 0);
    tick();
    check({t, ".result_held"}, o_lanes_result, v.exp_result);

    i_en = 1'b0;
    tick();
    check({t, ".ack_clr"}, o_point_test_ack, 0);
    check({t, ".result_clr"}, o_lanes_result, 0);
    tick();
  endtask

  initial begin
    int lat;
    int cnt;

    vecs[0] = '{lfsr: 1'b1, mb: 1'b1, data: 16'hFF0F, delay: 3, exp_result: 16'hFF0F};
    vecs[1] = '{lfsr: 1'b0, mb: 1'b0, data: 16'h0001, delay: 3, exp_result: 16'hFFFF};
    vecs[2] = '{lfsr: 1'b1, mb: 1'b0, data: 16'hFFFE, delay: 0, exp_result: 16'h0000};
    vecs[3] = '{lfsr: 1'b0, mb: 1'b1, data: 16'hA5C3, delay: 7, exp_result: 16'hA5C3};

    rst = 1'b1;
    i_en = 1'b0;
    i_tx_lfsr_or_perlane = 1'b0;
    i_tx_mainband_or_valtrain_test = 1'b0;
    i_sideband_message = 4'd0;
    i_sideband_valid = 1'b0;
    i_sideband_data = 16'h0;
    i_busy = 1'b0;
    i_pattern_done = 1'b0;
    repeat (3) tick();
    check("rst.msg", o_sideband_message, 0);
    check("rst.valid", o_valid, 0);
    check("rst.pattern_en", o_pattern_en, 0);
    check("rst.pattern_lfsr", o_pattern_lfsr, 0);
    check("rst.lfsr_clear", o_lfsr_clear, 0);
    check("rst.ack", o_point_test_ack, 0);
    check("rst.result", o_lanes_result, 0);
    check("rst.timeout", o_timeout, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) run_vector(vecs[i], i);

    // Busy stall in SEND_START.
    i_tx_lfsr_or_perlane = 1'b1;
    i_tx_mainband_or_valtrain_test = 1'b1;
    i_en = 1'b1;
    i_busy = 1'b1;
    cnt = 0;
    repeat (20) begin
      tick();
      if (o_valid) cnt++;
    end
    check("busy.no_valid", cnt, 0);
    check("busy.msg_held", o_sideband_message, 1);
    i_busy = 1'b0;
    tick();
    check("busy.valid_after", o_valid, 1);
    tick();
    check("busy.single_pulse", o_valid, 0);
    cnt = 0;
    repeat (4) begin
      tick();
      if (o_valid) cnt++;
    end
    check("busy.no_extra", cnt, 0);
    i_en = 1'b0;
    tick();

    // Timeout: no START_RESP.
    i_en = 1'b1;
    wait_valid(lat);
    tick();
    cnt = 0;
    while (!o_point_test_ack && cnt < 300) begin
      tick();
      cnt++;
    end
    check("timeout.cycles", cnt, TO);
    check("timeout.flag", o_timeout, 1);
    check("timeout.result", o_lanes_result, 0);
    repeat (3) tick();
    check("timeout.ack_held", o_point_test_ack, 1);
    i_en = 1'b0;
    tick();
    check("timeout.flag_clr", o_timeout, 0);
    tick();

    // Response on the terminal-count cycle wins over the timeout.
    i_en = 1'b1;
    wait_valid(lat);
    tick();
    repeat (TO - 1) tick();
    check("tc_race.no_ack_yet", o_point_test_ack, 0);
    respond(START_RESP, 16'h0);
    wait_valid(lat);
    check("tc_race.lat", lat, 2);
    check("tc_race.code", o_sideband_message, 3);
    check("tc_race.timeout", o_timeout, 0);
    i_en = 1'b0;
    tick();
    tick();

    // Abort during PATTERN, then restart.
    i_en = 1'b1;
    wait_valid(lat);
    tick();
    respond(START_RESP, 16'h0);
    wait_valid(lat);
    tick();
    respond(CLEAR_RESP, 16'h0);
    tick();
    check("abort.pattern_en_on", o_pattern_en, 1);
    repeat (2) tick();
    i_en = 1'b0;
    tick();
    check("abort.pattern_en_off", o_pattern_en, 0);
    check("abort.ack", o_point_test_ack, 0);
    check("abort.msg", o_sideband_message, 0);
    i_en = 1'b1;
    wait_valid(lat);
    check("abort.restart_lat", lat, 2);
    check("abort.restart_code", o_sideband_message, 1);
    i_en = 1'b0;
    tick();
    tick();

    // Spurious END_RESP in WAIT_START is ignored.
    i_en = 1'b1;
    wait_valid(lat);
    tick();
    respond(END_RESP, 16'h0);
    cnt = 0;
    repeat (4) begin
      tick();
      if (o_valid || o_point_test_ack) cnt++;
    end
    check("spurious.ignored", cnt, 0);
    respond(START_RESP, 16'h0);
    wait_valid(lat);
    check("spurious.advance_lat", lat, 2);
    check("spurious.advance_code", o_sideband_message, 3);
    i_en = 1'b0;
    tick();
    tick();

    // i_en=0 and a response in the same cycle: the abort wins.
    i_en = 1'b1;
    wait_valid(lat);
    tick();
    respond(START_RESP, 16'h0);
    i_en = 1'b0;
    tick();
    check("en_race.msg", o_sideband_message, 0);
    check("en_race.valid", o_valid, 0);
    tick();

    // Asynchronous reset mid-test.
    i_tx_lfsr_or_perlane = 1'b1;
    i_en = 1'b1;
    tick();
    check("midrst.msg_before", o_sideband_message, 1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst.msg", o_sideband_message, 0);
    check("midrst.pattern_lfsr", o_pattern_lfsr, 0);
    check("midrst.valid", o_valid, 0);
    i_en = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    cnt = 0;
    repeat (5) begin
      tick();
      if (o_valid) cnt++;
    end
    check("midrst.no_send", cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/tx_point_test_ctrl.md
# tx_point_test_ctrl

Sequencer for the TX-initiated point test used by the MBTRAIN sub-states (link-speed check, repair, valtrain). It sits directly downstream of the link-speed stage. It consumes that stage's point-test enable and mode selects, runs the start / LFSR-clear / pattern / result / end sideband exchange with the partner, and returns a point-test ack with the 16-lane pass mask.

## Interface
- TIMEOUT_CYCLES, 8000000: cycles allowed in any wait state before abort (8 ms at 1 GHz).
- CNT_W, 23: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.
- clk  in  1  single clock for the block.
- rst  in  1  asynchronous, active-high reset.
- i_en  in  1  point-test enable from the link-speed stage; level, held for the whole test.
- i_tx_lfsr_or_perlane  in  1  1 = LFSR pattern, 0 = per-lane ID pattern; sampled on leaving IDLE.
- i_tx_mainband_or_valtrain_test  in  1  1 = mainband (16 lanes), 0 = valtrain (1 lane); sampled on leaving IDLE.
- i_sideband_message  in  4  received decoded message.
- i_sideband_valid  in  1  i_sideband_message is valid this cycle.
- i_sideband_data  in  16  remote per-lane result; valid with RESULT_RESP.
- i_busy  in  1  sideband TX busy.
- i_pattern_done  in  1  one-cycle pulse from the pattern generator at the end of the burst.
- o_sideband_message  out  4  message to send.
- o_valid  out  1  one-cycle send strobe.
- o_pattern_en  out  1  pattern generator enable.
- o_pattern_lfsr  out  1  registered copy of i_tx_lfsr_or_perlane.
- o_lfsr_clear  out  1  one-cycle local LFSR/comparator clear.
- o_point_test_ack  out  1  test finished (pass, fail or timeout).
- o_lanes_result  out  16  per-lane pass mask.
- o_timeout  out  1  the test ended by timeout.

## Operation
- Message codes: START_REQ=1, START_RESP=2, CLEAR_REQ=3, CLEAR_RESP=4, RESULT_REQ=5, RESULT_RESP=6, END_REQ=7, END_RESP=8; 0 = none.
- States: IDLE, SEND_START, WAIT_START, SEND_CLEAR, WAIT_CLEAR, PATTERN, SEND_RESULT, WAIT_RESULT, SEND_END, WAIT_END, DONE.
- IDLE -> SEND_START when i_en=1. Both mode selects are latched on this transition.
- SEND_x states:
  - o_sideband_message holds the code.
  - o_valid pulses for exactly one cycle on the first cycle with i_busy=0.
  - The FSM moves to the matching WAIT_x on the cycle after the pulse.
- WAIT_x states advance on i_sideband_valid=1 with the expected response code; any other code is ignored.
  - WAIT_START -> SEND_CLEAR.
  - WAIT_CLEAR -> PATTERN; o_lfsr_clear pulses on this transition.
  - WAIT_RESULT -> SEND_END; i_sideband_data is captured here.
  - WAIT_END -> DONE.
- PATTERN: o_pattern_en=1 until i_pattern_done, then -> SEND_RESULT (o_pattern_en drops that same transition).
- Result computation:
  - Mainband: o_lanes_result = captured data.
  - Valtrain: o_lanes_result = {16{data[0]}}.
- Timeout counter:
  - Clears on every state change.
  - Counts in every state except IDLE and DONE.
  - On reaching TIMEOUT_CYCLES-1: go to DONE, set o_timeout=1, and set o_lanes_result=0.
- DONE: o_point_test_ack=1; results are held while i_en=1.
- i_en=0 in any state returns the FSM to IDLE next cycle and clears ack, timeout, result, and pattern_en. A send in flight is abandoned.
- Responses arriving in a state that does not expect them are dropped.

## Timing
- Reset values:
  - State IDLE; counter 0.
  - o_sideband_message=0, o_valid=0, o_pattern_en=0, o_pattern_lfsr=0, o_lfsr_clear=0, o_point_test_ack=0, o_lanes_result=0, o_timeout=0.
- All outputs are registered.
- i_en rising at cycle N with i_busy=0: state is SEND_START at N+1, o_valid=1 at N+2.
- A response at cycle M in a WAIT state is reflected in the new state at M+1.
- o_lfsr_clear and o_pattern_en first assert at M+1 after CLEAR_RESP.
- o_point_test_ack rises one cycle after the END_RESP cycle.
- i_busy held high stalls SEND_x without limit except for the timeout; o_valid never asserts while i_busy=1.
- A response and i_en=0 in the same cycle: i_en=0 wins.
- A timeout terminal count and the expected response in the same cycle: the response wins.
- Asserting rst mid-test forces reset values immediately; no sideband message is emitted afterwards.

## Test plan
- Mainband LFSR happy path: i_en=1, model responds after 3 cycles each, RESULT_RESP data=16'hFF0F -> o_valid pulses carry codes 1,3,5,7 in order; o_lfsr_clear pulses once; ack=1 with o_lanes_result=16'hFF0F and o_timeout=0.
- Valtrain per-lane: mode bits 0/0, data=16'h0001 -> o_pattern_lfsr=0; o_lanes_result=16'hFFFF.
- Busy stall: i_busy=1 for 20 cycles in SEND_START -> o_valid stays 0; exactly one o_valid pulse comes 1 cycle after busy falls.
- Timeout: TIMEOUT_CYCLES=100, no START_RESP -> ack=1 and o_timeout=1 exactly 100 cycles after entering WAIT_START; o_lanes_result=0.
- Abort: drop i_en during PATTERN -> next cycle state IDLE, o_pattern_en=0, ack=0; re-raising i_en restarts with code 1.
- Spurious messages: END_RESP injected in WAIT_START -> ignored, FSM stays; the later START_RESP advances normally.
